// File: rtl/arp_pkg.sv
// Shared ARP constants, FSM state types and a small MAC helper.
package arp_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH     = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4    = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH      = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4     = 8'd4;
  localparam logic [15:0] ARP_OPER_REQUEST  = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY    = 16'h0002;
  localparam int          ARP_PAYLOAD_WORDS = 7;

  typedef enum logic {
    RX_IDLE,
    RX_BODY
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_WAIT,
    TX_START,
    TX_DATA,
    TX_COMMIT
  } tx_state_t;

  // The I/G bit (LSB of the first octet) marks multicast; broadcast has it set too.
  function automatic logic is_group_mac(input logic [47:0] mac);
    return mac[40];
  endfunction

endpackage

// File: rtl/arp_reply_tx.sv
// One-deep ARP reply buffer and TX framing FSM.
module arp_reply_tx
  import arp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        queue_i,
  input  logic [47:0] req_sha_i,
  input  logic [31:0] req_spa_i,
  input  logic [47:0] our_mac_i,
  input  logic [31:0] our_ip_i,
  input  logic        tx_ready_i,
  output logic        tx_start_o,
  output logic        tx_data_valid_o,
  output logic        tx_commit_o,
  output logic [2:0]  tx_bytes_valid_o,
  output logic [31:0] tx_data_o,
  output logic [47:0] tx_dst_mac_o
);

  localparam logic [2:0] LAST_WORD = 3'(ARP_PAYLOAD_WORDS - 1);

  tx_state_t   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        load, snap;
  logic [47:0] req_sha_q;
  logic [31:0] req_spa_q;
  logic [47:0] mac_q;
  logic [31:0] ip_q;
  logic [31:0] word;

  // Next-state logic: a queued request is only accepted while idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    snap    = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (queue_i) begin
          state_d = TX_WAIT;
          load    = 1'b1;
        end
      end
      TX_WAIT: begin
        if (tx_ready_i) begin
          state_d = TX_START;
          snap    = 1'b1;
        end
      end
      TX_START: begin
        state_d = TX_DATA;
        cnt_d   = 3'd0;
      end
      TX_DATA: begin
        if (cnt_q == LAST_WORD) state_d = TX_COMMIT;
        else                    cnt_d   = cnt_q + 3'd1;
      end
      TX_COMMIT: state_d = TX_IDLE;
      default:   state_d = TX_IDLE;
    endcase
  end

  // Control state; reset aborts any reply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reply payload: requester captured at queue time, local addresses when the frame starts.
  always_ff @(posedge clk) begin
    if (load) begin
      req_sha_q <= req_sha_i;
      req_spa_q <= req_spa_i;
    end
    if (snap) begin
      mac_q <= our_mac_i;
      ip_q  <= our_ip_i;
    end
  end

  // Reply word selection in ARP wire order (sender = us, target = requester).
  always_comb begin
    word = 32'h0;
    case (cnt_q)
      3'd0:    word = {ARP_HTYPE_ETH, ARP_PTYPE_IPV4};
      3'd1:    word = {ARP_HLEN_ETH, ARP_PLEN_IPV4, ARP_OPER_REPLY};
      3'd2:    word = mac_q[47:16];
      3'd3:    word = {mac_q[15:0], ip_q[31:16]};
      3'd4:    word = {ip_q[15:0], req_sha_q[47:32]};
      3'd5:    word = req_sha_q[31:0];
      3'd6:    word = req_spa_q;
      default: word = 32'h0;
    endcase
  end

  assign tx_start_o       = (state_q == TX_START);
  assign tx_data_valid_o  = (state_q == TX_DATA);
  assign tx_commit_o      = (state_q == TX_COMMIT);
  assign tx_bytes_valid_o = tx_data_valid_o ? 3'd4 : 3'd0;
  assign tx_data_o        = tx_data_valid_o ? word : 32'h0;
  assign tx_dst_mac_o     = (tx_start_o || tx_data_valid_o || tx_commit_o) ? req_sha_q : 48'h0;

endmodule

// File: rtl/arp_protocol_engine.sv
// ARP receive parser: validates payloads, pulses learn bindings, queues replies.
module arp_protocol_engine
  import arp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] our_mac,
  input  logic [31:0] our_ip,
  input  logic        rx_start,
  input  logic        rx_data_valid,
  input  logic [2:0]  rx_bytes_valid,
  input  logic [31:0] rx_data,
  input  logic        rx_commit,
  input  logic        rx_drop,
  output logic        learn_en,
  output logic [31:0] learn_ip,
  output logic [47:0] learn_mac,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic        tx_data_valid,
  output logic        tx_commit,
  output logic [2:0]  tx_bytes_valid,
  output logic [31:0] tx_data,
  output logic [47:0] tx_dst_mac
);

  rx_state_t   rx_state_q, rx_state_d;
  logic [2:0]  idx_q, idx_d;
  logic        short_q, short_d;
  logic        hdr_ok_q, hdr_ok_d;
  logic        len_ok_q, len_ok_d;
  logic [15:0] oper_q;
  logic [47:0] sha_q;
  logic [31:0] spa_q;
  logic [31:0] tpa_q;
  logic        word_en;
  logic        pkt_valid;
  logic        commit_ok;
  logic        learn_d;
  logic        queue_req;
  logic        learn_en_q;
  logic [31:0] learn_ip_q;
  logic [47:0] learn_mac_q;

  assign word_en = (rx_state_q == RX_BODY) && !rx_start && rx_data_valid;

  assign pkt_valid = (idx_q == 3'd7) && !short_q && hdr_ok_q && len_ok_q &&
                     ((oper_q == ARP_OPER_REQUEST) || (oper_q == ARP_OPER_REPLY)) &&
                     !is_group_mac(sha_q);

  // A simultaneous drop or restart overrides the commit.
  assign commit_ok = (rx_state_q == RX_BODY) && rx_commit && !rx_drop && !rx_start && pkt_valid;
  assign learn_d   = commit_ok && (tpa_q == our_ip);
  assign queue_req = learn_d && (oper_q == ARP_OPER_REQUEST);

  // RX next-state, word index and header-check flags.
  always_comb begin
    rx_state_d = rx_state_q;
    idx_d      = idx_q;
    short_d    = short_q;
    hdr_ok_d   = hdr_ok_q;
    len_ok_d   = len_ok_q;
    if (rx_start) begin
      rx_state_d = RX_BODY;
      idx_d      = 3'd0;
      short_d    = 1'b0;
      hdr_ok_d   = 1'b0;
      len_ok_d   = 1'b0;
    end else if (rx_state_q == RX_BODY) begin
      if (rx_commit || rx_drop) rx_state_d = RX_IDLE;
      if (word_en && (idx_q != 3'd7)) begin
        idx_d = idx_q + 3'd1;
        if (rx_bytes_valid != 3'd4) short_d = 1'b1;
        if (idx_q == 3'd0) hdr_ok_d = (rx_data == {ARP_HTYPE_ETH, ARP_PTYPE_IPV4});
        if (idx_q == 3'd1) len_ok_d = (rx_data[31:16] == {ARP_HLEN_ETH, ARP_PLEN_IPV4});
      end
    end
  end

  // RX control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      idx_q      <= 3'd0;
      short_q    <= 1'b0;
      hdr_ok_q   <= 1'b0;
      len_ok_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      idx_q      <= idx_d;
      short_q    <= short_d;
      hdr_ok_q   <= hdr_ok_d;
      len_ok_q   <= len_ok_d;
    end
  end

  // Field capture by word index; padding beyond w6 never reaches here.
  always_ff @(posedge clk) begin
    if (word_en && (idx_q != 3'd7)) begin
      case (idx_q)
        3'd1: oper_q <= rx_data[15:0];
        3'd2: sha_q[47:16] <= rx_data;
        3'd3: begin
          sha_q[15:0]  <= rx_data[31:16];
          spa_q[31:16] <= rx_data[15:0];
        end
        3'd4: spa_q[15:0] <= rx_data[31:16];
        3'd6: tpa_q <= rx_data;
        default: ;
      endcase
    end
  end

  // Learn pulse and held binding, one cycle after commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      learn_en_q  <= 1'b0;
      learn_ip_q  <= 32'h0;
      learn_mac_q <= 48'h0;
    end else begin
      learn_en_q <= learn_d;
      if (learn_d) begin
        learn_ip_q  <= spa_q;
        learn_mac_q <= sha_q;
      end
    end
  end

  assign learn_en  = learn_en_q;
  assign learn_ip  = learn_ip_q;
  assign learn_mac = learn_mac_q;

  arp_reply_tx u_reply_tx (
    .clk              (clk),
    .rst_n            (rst_n),
    .queue_i          (queue_req),
    .req_sha_i        (sha_q),
    .req_spa_i        (spa_q),
    .our_mac_i        (our_mac),
    .our_ip_i         (our_ip),
    .tx_ready_i       (tx_ready),
    .tx_start_o       (tx_start),
    .tx_data_valid_o  (tx_data_valid),
    .tx_commit_o      (tx_commit),
    .tx_bytes_valid_o (tx_bytes_valid),
    .tx_data_o        (tx_data),
    .tx_dst_mac_o     (tx_dst_mac)
  );

endmodule

// File: tb/tb_arp_protocol_engine.sv
// Scoreboard bench for arp_protocol_engine with directed ARP frames.
module tb_arp_protocol_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] our_mac = 48'h0A0B0C0D0E0F;
  logic [31:0] our_ip = 32'h0A000001;
  logic        rx_start = 1'b0;
  logic        rx_data_valid = 1'b0;
  logic [2:0]  rx_bytes_valid = 3'd0;
  logic [31:0] rx_data = 32'h0;
  logic        rx_commit = 1'b0;
  logic        rx_drop = 1'b0;
  logic        learn_en;
  logic [31:0] learn_ip;
  logic [47:0] learn_mac;
  logic        tx_ready = 1'b0;
  logic        tx_start, tx_data_valid, tx_commit;
  logic [2:0]  tx_bytes_valid;
  logic [31:0] tx_data;
  logic [47:0] tx_dst_mac;

  arp_protocol_engine dut (
    .clk(clk), .rst_n(rst_n), .our_mac(our_mac), .our_ip(our_ip),
    .rx_start(rx_start), .rx_data_valid(rx_data_valid), .rx_bytes_valid(rx_bytes_valid),
    .rx_data(rx_data), .rx_commit(rx_commit), .rx_drop(rx_drop),
    .learn_en(learn_en), .learn_ip(learn_ip), .learn_mac(learn_mac),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data_valid(tx_data_valid),
    .tx_commit(tx_commit), .tx_bytes_valid(tx_bytes_valid), .tx_data(tx_data),
    .tx_dst_mac(tx_dst_mac)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] ip; logic [47:0] mac; } learn_t;
  typedef struct { int cyc; logic [47:0] dst; } start_t;

  learn_t      lq[$];
  start_t      sq[$];
  logic [31:0] wq[$];
  int          cq[$];

  int total = 0;
  int pass  = 0;

  localparam logic [47:0] SHA_A = 48'h021122334455;
  localparam logic [31:0] SPA_A = 32'h0A000005;
  localparam logic [47:0] SHA_B = 48'h02AABBCCDDEE;
  localparam logic [31:0] SPA_B = 32'h0A000006;

  // Hand-computed reply to requester A with our_mac 0A0B0C0D0E0F / our_ip 10.0.0.1.
  logic [31:0] rpl_a [7] = '{32'h00010800, 32'h06040002, 32'h0A0B0C0D, 32'h0E0F0A00,
                             32'h00010211, 32'h22334455, 32'h0A000005};

  logic [31:0] pkt [7];
  int          commit_cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic spurious(input string nm);
    total++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  task automatic check_zero(input string nm);
    chk(nm, 64'(|{learn_en, learn_ip, learn_mac, tx_start, tx_data_valid, tx_commit,
                  tx_bytes_valid, tx_data, tx_dst_mac}), 64'd0);
  endtask

  task automatic build(input logic [15:0] ptype, input logic [15:0] oper,
                       input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa);
    pkt[0] = {16'h0001, ptype};
    pkt[1] = {8'd6, 8'd4, oper};
    pkt[2] = sha[47:16];
    pkt[3] = {sha[15:0], spa[31:16]};
    pkt[4] = {spa[15:0], 16'h0000};
    pkt[5] = 32'h0;
    pkt[6] = tpa;
  endtask

  // rx_start, nwords payload words, npad 2-byte padding words, then commit or drop.
  task automatic send(input int nwords, input int npad, input bit drop);
    @(posedge clk); #1;
    rx_start = 1'b1;
    @(posedge clk); #1;
    rx_start = 1'b0;
    for (int i = 0; i < nwords + npad; i++) begin
      rx_data_valid  = 1'b1;
      rx_bytes_valid = (i < nwords) ? 3'd4 : 3'd2;
      rx_data        = (i < nwords) ? pkt[i] : 32'hAAAA0000;
      @(posedge clk); #1;
    end
    rx_data_valid  = 1'b0;
    rx_bytes_valid = 3'd0;
    if (drop) rx_drop = 1'b1;
    else      rx_commit = 1'b1;
    commit_cyc = cyc;
  endtask

  task automatic end_commit();
    @(posedge clk); #1;
    rx_commit = 1'b0;
    rx_drop   = 1'b0;
  endtask

  task automatic expect_reply_a(input int start_cyc);
    sq.push_back('{start_cyc, SHA_A});
    for (int i = 0; i < 7; i++) wq.push_back(rpl_a[i]);
    cq.push_back(1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    int st_cyc = 0;
    int widx = 0;
    learn_t le;
    start_t se;
    logic [31:0] w;
    int c;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        widx = 0;
      end else begin
        if (learn_en) begin
          if (lq.size() == 0) spurious("learn_en");
          else begin
            le = lq.pop_front();
            chk("learn_cycle", 64'(cyc), 64'(le.cyc));
            chk("learn_ip", 64'(learn_ip), 64'(le.ip));
            chk("learn_mac", 64'(learn_mac), 64'(le.mac));
          end
        end
        if (tx_start) begin
          if (sq.size() == 0) spurious("tx_start");
          else begin
            se = sq.pop_front();
            chk("tx_start_cycle", 64'(cyc), 64'(se.cyc));
            chk("tx_start_dst", 64'(tx_dst_mac), 64'(se.dst));
          end
          st_cyc = cyc;
          widx = 0;
        end
        if (tx_data_valid) begin
          if (wq.size() == 0) spurious("tx_data_valid");
          else begin
            w = wq.pop_front();
            chk($sformatf("tx_word%0d", widx), 64'(tx_data), 64'(w));
            chk("tx_bytes_valid", 64'(tx_bytes_valid), 64'd4);
            chk("tx_word_cycle", 64'(cyc), 64'(st_cyc + 1 + widx));
            chk("tx_data_dst", 64'(tx_dst_mac), 64'(SHA_A));
          end
          widx++;
        end
        if (tx_commit) begin
          if (cq.size() == 0) spurious("tx_commit");
          else begin
            c = cq.pop_front();
            chk("tx_commit_cycle", 64'(cyc), 64'(st_cyc + 8));
            chk("tx_commit_dst", 64'(tx_dst_mac), 64'(SHA_A));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 check_zero("reset_outputs");
    rst_n = 1'b1;
    tx_ready = 1'b1;

    // Request to us, tx_ready high, with trailing padding
    build(16'h0800, 16'h0001, SHA_A, SPA_A, 32'h0A000001);
    send(7, 2, 1'b0);
    lq.push_back('{commit_cyc + 1, SPA_A, SHA_A});
    expect_reply_a(commit_cyc + 2);
    end_commit();
    repeat (14) @(posedge clk);

    // Request for another host: nothing; binding held
    build(16'h0800, 16'h0001, SHA_B, SPA_B, 32'h0A000009);
    send(7, 0, 1'b0);
    end_commit();
    repeat (14) @(posedge clk);
    #1 chk("learn_ip_held", 64'(learn_ip), 64'(SPA_A));
    chk("learn_mac_held", 64'(learn_mac), 64'(SHA_A));

    // Reply addressed to us: learn only
    build(16'h0800, 16'h0002, SHA_B, SPA_B, 32'h0A000001);
    send(7, 0, 1'b0);
    lq.push_back('{commit_cyc + 1, SPA_B, SHA_B});
    end_commit();
    repeat (14) @(posedge clk);

    // Invalid frames: drop, IPv6 PTYPE, short frame, multicast sender
    build(16'h0800, 16'h0001, SHA_A, SPA_A, 32'h0A000001);
    send(7, 0, 1'b1);
    end_commit();
    build(16'h86DD, 16'h0001, SHA_A, SPA_A, 32'h0A000001);
    send(7, 0, 1'b0);
    end_commit();
    build(16'h0800, 16'h0001, SHA_A, SPA_A, 32'h0A000001);
    send(6, 0, 1'b0);
    end_commit();
    build(16'h0800, 16'h0001, 48'h031122334455, SPA_A, 32'h0A000001);
    send(7, 0, 1'b0);
    end_commit();
    repeat (14) @(posedge clk);

    // Valid request after the rejects
    build(16'h0800, 16'h0001, SHA_A, SPA_A, 32'h0A000001);
    send(7, 0, 1'b0);
    lq.push_back('{commit_cyc + 1, SPA_A, SHA_A});
    expect_reply_a(commit_cyc + 2);
    end_commit();
    repeat (14) @(posedge clk);

    // Back-to-back requests with tx_ready low: both learned, one reply (A)
    #1 tx_ready = 1'b0;
    build(16'h0800, 16'h0001, SHA_A, SPA_A, 32'h0A000001);
    send(7, 0, 1'b0);
    lq.push_back('{commit_cyc + 1, SPA_A, SHA_A});
    end_commit();
    build(16'h0800, 16'h0001, SHA_B, SPA_B, 32'h0A000001);
    send(7, 0, 1'b0);
    lq.push_back('{commit_cyc + 1, SPA_B, SHA_B});
    end_commit();
    repeat (4) @(posedge clk);
    #1 tx_ready = 1'b1;
    expect_reply_a(cyc + 1);
    repeat (16) @(posedge clk);

    // Reset during TX_DATA word 3
    build(16'h0800, 16'h0001, SHA_A, SPA_A, 32'h0A000001);
    send(7, 0, 1'b0);
    lq.push_back('{commit_cyc + 1, SPA_A, SHA_A});
    expect_reply_a(commit_cyc + 2);
    end_commit();
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset_outputs");
    chk("words_before_reset", 64'(wq.size()), 64'd4);
    lq.delete();
    sq.delete();
    wq.delete();
    cq.delete();
    repeat (3) @(posedge clk);
    #1 check_zero("held_reset_outputs");
    rst_n = 1'b1;

    // Fresh request after reset is fully served
    build(16'h0800, 16'h0001, SHA_A, SPA_A, 32'h0A000001);
    send(7, 0, 1'b0);
    lq.push_back('{commit_cyc + 1, SPA_A, SHA_A});
    expect_reply_a(commit_cyc + 2);
    end_commit();
    repeat (16) @(posedge clk);

    #1;
    chk("learn_queue_drained", 64'(lq.size()), 64'd0);
    chk("start_queue_drained", 64'(sq.size()), 64'd0);
    chk("word_queue_drained", 64'(wq.size()), 64'd0);
    chk("commit_queue_drained", 64'(cq.size()), 64'd0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
